// File: rtl/branch_predictor_pkg.sv
// Shared types for the branch predictor: 2-bit counter states and BTB entry.
package branch_predictor_pkg;

  localparam int BP_XLEN    = 32;
  localparam int BP_ENTRIES = 16;
  localparam int BP_IDX_W   = $clog2(BP_ENTRIES);
  localparam int BP_TAG_W   = BP_XLEN - BP_IDX_W - 2;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    logic [BP_XLEN-1:0]  target;
    ctr_e                ctr;
  } btb_entry_t;

  // Saturating step of a 2-bit counter: up on taken, down on not-taken.
  function automatic ctr_e ctr_step(input ctr_e c, input logic up);
    ctr_e n;
    n = c;
    case (c)
      CTR_SNT: n = up ? CTR_WNT : CTR_SNT;
      CTR_WNT: n = up ? CTR_WT  : CTR_SNT;
      CTR_WT:  n = up ? CTR_ST  : CTR_WNT;
      CTR_ST:  n = up ? CTR_ST  : CTR_WT;
      default: n = c;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/branch_predictor_btb_table.sv
// Direct-mapped BTB: combinational fetch-side lookup plus one update port
// driven by resolved branches (update/allocate/invalidate).
`include "defines.sv"

module branch_predictor_btb_table
  import branch_predictor_pkg::*;
#(
  parameter int XLEN    = BP_XLEN,
  parameter int ENTRIES = BP_ENTRIES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  rd_pc_i,
  output logic             rd_taken_o,
  output logic [XLEN-1:0]  rd_target_o,
  input  logic             upd_valid_i,
  input  logic [XLEN-1:0]  upd_pc_i,
  input  logic [`BJ_OP_BUS] upd_op_i,
  input  logic             upd_taken_i,
  input  logic [XLEN-1:0]  upd_target_i
);

  localparam int IDX_W = $clog2(ENTRIES);

  btb_entry_t            table_q [ENTRIES];
  logic [IDX_W-1:0]      rd_idx;
  logic [IDX_W-1:0]      upd_idx;
  logic                  rd_hit;
  logic                  upd_hit;
  logic                  wr_en;
  btb_entry_t            wr_entry;
  logic                  unused_pc_lsbs;

  assign rd_idx  = rd_pc_i[IDX_W+1:2];
  assign upd_idx = upd_pc_i[IDX_W+1:2];
  assign unused_pc_lsbs = ^{rd_pc_i[1:0], upd_pc_i[1:0]};

  // Read port sees pre-write contents; a same-cycle update lands next cycle.
  assign rd_hit      = table_q[rd_idx].valid &&
                       (table_q[rd_idx].tag == rd_pc_i[XLEN-1:IDX_W+2]);
  assign rd_taken_o  = rd_hit && table_q[rd_idx].ctr[1];
  assign rd_target_o = rd_taken_o ? table_q[rd_idx].target : '0;

  assign upd_hit = table_q[upd_idx].valid &&
                   (table_q[upd_idx].tag == upd_pc_i[XLEN-1:IDX_W+2]);

  // Build the entry to write for the resolved op; undefined ops act as NOOP.
  always_comb begin
    wr_en    = 1'b0;
    wr_entry = table_q[upd_idx];
    if (upd_valid_i) begin
      case (upd_op_i)
        `EXE_BJOP_JUMP: begin
          wr_en           = 1'b1;
          wr_entry.valid  = 1'b1;
          wr_entry.tag    = upd_pc_i[XLEN-1:IDX_W+2];
          wr_entry.target = upd_target_i;
          wr_entry.ctr    = CTR_ST;
        end
        `EXE_BJOP_BEQ, `EXE_BJOP_BNE, `EXE_BJOP_BLT,
        `EXE_BJOP_BGE, `EXE_BJOP_BLTU, `EXE_BJOP_BGEU: begin
          if (upd_hit) begin
            wr_en        = 1'b1;
            wr_entry.ctr = ctr_step(table_q[upd_idx].ctr, upd_taken_i);
            if (upd_taken_i) wr_entry.target = upd_target_i;
          end else if (upd_taken_i) begin
            wr_en           = 1'b1;
            wr_entry.valid  = 1'b1;
            wr_entry.tag    = upd_pc_i[XLEN-1:IDX_W+2];
            wr_entry.target = upd_target_i;
            wr_entry.ctr    = CTR_WT;
          end
        end
        default: begin
          // A hit on a non-branch means a stale alias: drop it.
          if (upd_hit) begin
            wr_en          = 1'b1;
            wr_entry.valid = 1'b0;
          end
        end
      endcase
    end
  end

  // Table storage: reset clears every entry to invalid / weakly-not-taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};
      end
    end else if (wr_en) begin
      table_q[upd_idx] <= wr_entry;
    end
  end

endmodule

// File: rtl/defines.sv
// Branch/jump operation encodings shared with the execute-stage resolver.
`ifndef BRANCH_PREDICTOR_DEFINES_SV
`define BRANCH_PREDICTOR_DEFINES_SV

`define BJ_OP_BUS      3:0

`define EXE_BJOP_NOOP  4'd0
`define EXE_BJOP_JUMP  4'd1
`define EXE_BJOP_BEQ   4'd2
`define EXE_BJOP_BNE   4'd3
`define EXE_BJOP_BLT   4'd4
`define EXE_BJOP_BGE   4'd5
`define EXE_BJOP_BLTU  4'd6
`define EXE_BJOP_BGEU  4'd7

`endif

// File: rtl/branch_predictor.sv
// Branch predictor top: fetch prediction from the BTB, mispredict detection
// against the piped-down prediction, redirect register and statistics.
`include "defines.sv"

module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int XLEN    = BP_XLEN,
  parameter int ENTRIES = BP_ENTRIES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   if_pc,
  output logic              pred_taken,
  output logic [XLEN-1:0]   pred_target,
  input  logic              ex_valid,
  input  logic [XLEN-1:0]   ex_pc,
  input  logic [`BJ_OP_BUS] ex_bj_op,
  input  logic              ex_b_taken,
  input  logic [XLEN-1:0]   ex_target,
  input  logic              ex_pred_taken,
  input  logic [XLEN-1:0]   ex_pred_target,
  output logic              mispredict,
  output logic [XLEN-1:0]   redirect_pc,
  output logic [31:0]       branch_cnt,
  output logic [31:0]       mispredict_cnt
);

  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] actual_next;
  logic [XLEN-1:0] pred_next;
  logic            miss;
  logic            is_branch;

  logic            mispredict_q, mispredict_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic [31:0]     branch_cnt_q, branch_cnt_d;
  logic [31:0]     mispredict_cnt_q, mispredict_cnt_d;

  branch_predictor_btb_table #(
    .XLEN    (XLEN),
    .ENTRIES (ENTRIES)
  ) u_btb (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_pc_i      (if_pc),
    .rd_taken_o   (pred_taken),
    .rd_target_o  (pred_target),
    .upd_valid_i  (ex_valid),
    .upd_pc_i     (ex_pc),
    .upd_op_i     (ex_bj_op),
    .upd_taken_i  (ex_b_taken),
    .upd_target_i (ex_target)
  );

  // Compare what really comes next against what fetch assumed.
  assign seq_pc      = ex_pc + XLEN'(4);
  assign actual_next = ex_b_taken    ? ex_target      : seq_pc;
  assign pred_next   = ex_pred_taken ? ex_pred_target : seq_pc;
  assign miss        = (actual_next != pred_next);
  assign is_branch   = ex_bj_op inside {`EXE_BJOP_JUMP, `EXE_BJOP_BEQ, `EXE_BJOP_BNE,
                                        `EXE_BJOP_BLT, `EXE_BJOP_BGE, `EXE_BJOP_BLTU,
                                        `EXE_BJOP_BGEU};

  // Next-state for redirect pulse, redirect target and statistics.
  always_comb begin
    mispredict_d     = ex_valid && miss;
    redirect_pc_d    = ex_valid ? actual_next : redirect_pc_q;
    branch_cnt_d     = branch_cnt_q + 32'(ex_valid && is_branch);
    mispredict_cnt_d = mispredict_cnt_q + 32'(ex_valid && miss);
  end

  // Output registers; reset drops any pending redirect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mispredict_q     <= 1'b0;
      redirect_pc_q    <= '0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      mispredict_q     <= mispredict_d;
      redirect_pc_q    <= redirect_pc_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign mispredict     = mispredict_q;
  assign redirect_pc    = redirect_pc_q;
  assign branch_cnt     = branch_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed resolves, a behavioural BTB model
// checked every cycle, and literal expectations at key points.
module tb_branch_predictor;

  localparam logic [3:0] OP_NOOP  = 4'd0;
  localparam logic [3:0] OP_JUMP  = 4'd1;
  localparam logic [3:0] OP_BEQ   = 4'd2;
  localparam logic [3:0] OP_BNE   = 4'd3;
  localparam logic [3:0] OP_BLT   = 4'd4;
  localparam logic [3:0] OP_BGE   = 4'd5;
  localparam logic [3:0] OP_UNDEF = 4'hF;

  logic        clk;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [3:0]  ex_bj_op;
  logic        ex_b_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] branch_cnt;
  logic [31:0] mispredict_cnt;

  branch_predictor dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_bj_op       (ex_bj_op),
    .ex_b_taken     (ex_b_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .mispredict     (mispredict),
    .redirect_pc    (redirect_pc),
    .branch_cnt     (branch_cnt),
    .mispredict_cnt (mispredict_cnt)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: 16-entry table indexed by word address mod 16,
  // tag = pc/64, counter kept as a plain integer 0..3.
  logic        m_valid  [16];
  logic [31:0] m_tag    [16];
  logic [31:0] m_target [16];
  int          m_ctr    [16];
  logic        m_mis;
  logic [31:0] m_redir;
  logic [31:0] m_bcnt;
  logic [31:0] m_mcnt;
  bit          m_init = 0;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 32'd16);
  endfunction

  function automatic logic m_hit(input logic [31:0] pc);
    int i;
    i = idx_of(pc);
    return m_valid[i] && (m_tag[i] == (pc >> 6));
  endfunction

  task automatic model_update();
    int          i;
    logic        h;
    logic [31:0] act;
    logic [31:0] prd;
    if (!rst_n) begin
      for (int k = 0; k < 16; k++) begin
        m_valid[k] = 1'b0; m_tag[k] = '0; m_target[k] = '0; m_ctr[k] = 1;
      end
      m_mis = 1'b0; m_redir = '0; m_bcnt = '0; m_mcnt = '0;
      m_init = 1;
    end else if (ex_valid) begin
      act   = ex_b_taken ? ex_target : ex_pc + 32'd4;
      prd   = ex_pred_taken ? ex_pred_target : ex_pc + 32'd4;
      m_mis = (act != prd);
      m_redir = act;
      if (m_mis) m_mcnt = m_mcnt + 32'd1;
      if (ex_bj_op >= OP_JUMP && ex_bj_op <= 4'd7) m_bcnt = m_bcnt + 32'd1;
      i = idx_of(ex_pc);
      h = m_hit(ex_pc);
      if (ex_bj_op == OP_JUMP) begin
        m_valid[i] = 1'b1; m_tag[i] = ex_pc >> 6; m_target[i] = ex_target; m_ctr[i] = 3;
      end else if (ex_bj_op >= OP_BEQ && ex_bj_op <= 4'd7) begin
        if (h) begin
          m_ctr[i] = ex_b_taken ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3)
                                : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
          if (ex_b_taken) m_target[i] = ex_target;
        end else if (ex_b_taken) begin
          m_valid[i] = 1'b1; m_tag[i] = ex_pc >> 6; m_target[i] = ex_target; m_ctr[i] = 2;
        end
      end else if (h) begin
        m_valid[i] = 1'b0;
      end
    end else begin
      m_mis = 1'b0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_update();
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial forever begin
    logic        ptk;
    logic [31:0] ptg;
    @(negedge clk);
    if (m_init) begin
      ptk = m_hit(if_pc) && (m_ctr[idx_of(if_pc)] >= 2);
      ptg = ptk ? m_target[idx_of(if_pc)] : 32'd0;
      chk("cyc_pred_taken",  {31'd0, pred_taken}, {31'd0, ptk});
      chk("cyc_pred_target", pred_target, ptg);
      chk("cyc_mispredict",  {31'd0, mispredict}, {31'd0, m_mis});
      chk("cyc_redirect_pc", redirect_pc, m_redir);
      chk("cyc_branch_cnt",  branch_cnt, m_bcnt);
      chk("cyc_mis_cnt",     mispredict_cnt, m_mcnt);
    end
  end

  // Driver: present one resolved instruction for exactly one rising edge.
  task automatic resolve(input logic [31:0] pc, input logic [3:0] op, input logic tk,
                         input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    @(negedge clk); #1;
    if_pc          = pc;
    ex_pc          = pc;
    ex_bj_op       = op;
    ex_b_taken     = tk;
    ex_target      = tgt;
    ex_pred_taken  = ptk;
    ex_pred_target = ptgt;
    ex_valid       = 1'b1;
    @(posedge clk); #1;
    ex_valid = 1'b0;
  endtask

  task automatic look(input string name, input logic [31:0] pc, input logic tk, input logic [31:0] tg);
    if_pc = pc;
    #1;
    chk({name, "_taken"},  {31'd0, pred_taken}, {31'd0, tk});
    chk({name, "_target"}, pred_target, tg);
  endtask

  task automatic chk_out(input string name, input logic mis, input logic [31:0] rpc);
    chk({name, "_mis"},   {31'd0, mispredict}, {31'd0, mis});
    chk({name, "_redir"}, redirect_pc, rpc);
  endtask

  task automatic chk_cnt(input string name, input logic [31:0] b, input logic [31:0] m);
    chk({name, "_bcnt"}, branch_cnt, b);
    chk({name, "_mcnt"}, mispredict_cnt, m);
  endtask

  initial begin
    rst_n = 1'b0; if_pc = '0; ex_valid = 1'b0; ex_pc = '0; ex_bj_op = OP_NOOP;
    ex_b_taken = 1'b0; ex_target = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    look("rst", 32'h100, 1'b0, 32'h0);
    chk_out("rst", 1'b0, 32'h0);
    chk_cnt("rst", 32'd0, 32'd0);

    // Cold taken BEQ allocates with ctr=10
    resolve(32'h100, OP_BEQ, 1'b1, 32'h80, 1'b0, 32'h0);
    chk_out("beq_alloc", 1'b1, 32'h80);
    chk_cnt("beq_alloc", 32'd1, 32'd1);
    look("beq_alloc", 32'h100, 1'b1, 32'h80);

    // Not-taken twice: 10 -> 01 -> 00
    resolve(32'h100, OP_BEQ, 1'b0, 32'h80, 1'b1, 32'h80);
    chk_out("beq_nt1", 1'b1, 32'h104);
    look("beq_nt1", 32'h100, 1'b0, 32'h0);
    resolve(32'h100, OP_BEQ, 1'b0, 32'h80, 1'b0, 32'h0);
    chk_out("beq_nt2", 1'b0, 32'h104);
    chk_cnt("beq_nt2", 32'd3, 32'd2);

    // JUMP sets ctr=11, then not-taken BNEs walk down and saturate
    resolve(32'h200, OP_JUMP, 1'b1, 32'h400, 1'b0, 32'h0);
    chk_out("jump", 1'b1, 32'h400);
    look("jump", 32'h200, 1'b1, 32'h400);
    resolve(32'h200, OP_BNE, 1'b0, 32'h400, 1'b1, 32'h400);
    chk_out("bne1", 1'b1, 32'h204);
    look("bne1", 32'h200, 1'b1, 32'h400);
    resolve(32'h200, OP_BNE, 1'b0, 32'h400, 1'b1, 32'h400);
    chk_out("bne2", 1'b1, 32'h204);
    look("bne2", 32'h200, 1'b0, 32'h0);
    resolve(32'h200, OP_BNE, 1'b0, 32'h400, 1'b0, 32'h0);
    chk_out("bne3", 1'b0, 32'h204);
    resolve(32'h200, OP_BNE, 1'b0, 32'h400, 1'b0, 32'h0);
    chk_out("bne4", 1'b0, 32'h204);
    chk_cnt("bne4", 32'd8, 32'd5);
    // One taken from a saturated 00 only reaches 01: still predicts not-taken
    resolve(32'h200, OP_BNE, 1'b1, 32'h400, 1'b0, 32'h0);
    chk_out("bne_t", 1'b1, 32'h400);
    look("bne_t", 32'h200, 1'b0, 32'h0);
    chk_cnt("bne_t", 32'd9, 32'd6);

    // Aliasing: rebuild 0x100 to predict taken, 0x140 misses on tag,
    // NOOP with a stale prediction redirects to pc+4 and invalidates.
    resolve(32'h100, OP_BEQ, 1'b1, 32'h80, 1'b0, 32'h0);
    resolve(32'h100, OP_BEQ, 1'b1, 32'h80, 1'b0, 32'h0);
    look("alias_hit", 32'h100, 1'b1, 32'h80);
    look("alias_tag", 32'h140, 1'b0, 32'h0);
    resolve(32'h100, OP_NOOP, 1'b0, 32'h0, 1'b1, 32'h80);
    chk_out("noop", 1'b1, 32'h104);
    look("noop_inv", 32'h100, 1'b0, 32'h0);
    chk_cnt("noop", 32'd11, 32'd9);

    // Undefined op behaves as NOOP
    resolve(32'h300, OP_JUMP, 1'b1, 32'h10, 1'b0, 32'h0);
    look("j300", 32'h300, 1'b1, 32'h10);
    resolve(32'h300, OP_UNDEF, 1'b0, 32'h0, 1'b1, 32'h10);
    chk_out("undef", 1'b1, 32'h304);
    look("undef_inv", 32'h300, 1'b0, 32'h0);
    chk_cnt("undef", 32'd12, 32'd11);

    // pc+4 wraps at the top of the address space
    resolve(32'hFFFF_FFFC, OP_BGE, 1'b0, 32'h1234, 1'b0, 32'h0);
    chk_out("wrap", 1'b0, 32'h0);
    chk_cnt("wrap", 32'd13, 32'd11);

    // Mispredicting BLT followed by reset on the next edge
    resolve(32'h500, OP_BLT, 1'b1, 32'h600, 1'b0, 32'h0);
    chk_out("blt", 1'b1, 32'h600);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_out("blt_rst", 1'b0, 32'h0);
    chk_cnt("blt_rst", 32'd0, 32'd0);
    rst_n = 1'b1;
    look("post_rst_a", 32'h100, 1'b0, 32'h0);
    look("post_rst_b", 32'h500, 1'b0, 32'h0);

    // Reset on the same edge as a mispredicting resolve drops the redirect
    rst_n = 1'b0;
    resolve(32'h500, OP_BLT, 1'b1, 32'h600, 1'b0, 32'h0);
    chk_out("rst_same", 1'b0, 32'h0);
    rst_n = 1'b1;
    resolve(32'h500, OP_BLT, 1'b1, 32'h600, 1'b0, 32'h0);
    chk_out("after_rst", 1'b1, 32'h600);
    chk_cnt("after_rst", 32'd1, 32'd1);

    repeat (2) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side consumer of branch resolutions from the execute-stage branch/jump resolver (the block driving `b_taken` from `bj_op`, `rrd1`, `rrd2`).
- Holds a direct-mapped BTB with 2-bit saturating counters and gives fetch a next-PC prediction.
- On each resolved instruction, it compares the resolved outcome against the prediction carried down the pipe and issues a one-cycle redirect on mismatch.
- It closes the loop between execute-stage resolution and the fetch PC mux.

Parameters:
- XLEN, 32, PC/target width.
- ENTRIES, 16, BTB entries; power of 2, at least 2.
- IDX_W, $clog2(ENTRIES), derived index width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- if_pc  in  XLEN  current fetch PC
- pred_taken  out  1  fetch prediction: redirect to pred_target
- pred_target  out  XLEN  predicted target (0 when pred_taken=0)
- ex_valid  in  1  execute stage holds a valid instruction this cycle
- ex_pc  in  XLEN  PC of that instruction
- ex_bj_op  in  `BJ_OP_BUS`  branch/jump op (`EXE_BJOP_*` encodings)
- ex_b_taken  in  1  resolved taken from the resolver
- ex_target  in  XLEN  resolved branch/jump target
- ex_pred_taken  in  1  prediction made at fetch for this instruction, piped down
- ex_pred_target  in  XLEN  predicted target, piped down
- mispredict  out  1  one-cycle redirect pulse
- redirect_pc  out  XLEN  correct next PC, valid while mispredict=1
- branch_cnt  out  32  resolved non-NOOP ops, wrapping
- mispredict_cnt  out  32  mispredicts, wrapping

Behaviour:
- Entry fields: valid, tag = pc[XLEN-1:IDX_W+2], target, ctr[1:0].
- Index = pc[IDX_W+1:2]. PC bits [1:0] are ignored.
- Reset (rst_n=0 at a clk edge):
  - all valid=0, all ctr=2'b01.
  - mispredict=0, redirect_pc=0, branch_cnt=0, mispredict_cnt=0.
  - Reset mid-operation drops any pending redirect.
- Predict, combinational from table state:
  - hit = valid && tag match on if_pc.
  - pred_taken = hit && ctr[1]; pred_target = entry target when pred_taken, else 0.
  - A write and a read to the same index in the same cycle: the read returns pre-write contents. The update becomes visible the next cycle.
- Resolve, sampled when ex_valid=1:
  - actual_next = ex_b_taken ? ex_target : ex_pc+4.
  - pred_next = ex_pred_taken ? ex_pred_target : ex_pc+4.
  - All adds are XLEN-wide and wrap modulo 2^XLEN.
  - miss = (actual_next != pred_next).
  - Next cycle: mispredict = miss, redirect_pc = actual_next.
  - When ex_valid=0: mispredict=0 next cycle and redirect_pc holds its value.
- Table update, at the clock edge when ex_valid=1:
  - JUMP: write valid=1, tag, target=ex_target, ctr=2'b11.
  - Conditional op, hit: ctr saturating +1 if taken, -1 if not (11 stays 11, 00 stays 00). Target written only if taken.
  - Conditional op, no hit, taken: allocate, overwriting the slot, with ctr=2'b10.
  - Conditional op, no hit, not taken: no write.
  - NOOP, hit: clear valid (alias cleanup). A stale pred_taken=1 on a NOOP is a mispredict to ex_pc+4.
  - NOOP, no hit: no write.
  - Undefined bj_op values are treated as NOOP.
- Counters:
  - branch_cnt += 1 on ex_valid with a non-NOOP op.
  - mispredict_cnt += 1 when miss is registered.
  - Both wrap 0xFFFFFFFF -> 0.
- Latency: prediction 0 cycles; redirect 1 cycle after resolve.
- Back-to-back mispredicts produce consecutive pulses; each pulse carries its own redirect_pc.

Decomposition:
- Shared package: the 2-bit counter state typedef (SNT=00, WNT=01, WT=10, ST=11) and the BTB entry struct typedef.
- `EXE_BJOP_*` encodings and `BJ_OP_BUS` stay in defines.sv.
- One natural sub-module, btb_table:
  - storage array plus read port and tag compare.
  - single write port with update/allocate/invalidate logic.
- The top level keeps mispredict compare, output registers and the statistics counters.

Test Plan:
- Reset, then if_pc=0x100 -> pred_taken=0, pred_target=0, all counters 0.
- BEQ at ex_pc=0x100, taken, target 0x80, pred_taken=0 -> next cycle mispredict=1, redirect_pc=0x80. Then if_pc=0x100 -> pred_taken=1, pred_target=0x80, ctr=10.
- Same BEQ resolved not-taken twice, with predictions matching the table -> ctr 10->01->00, pred_taken=0. First resolve mispredicts to 0x104; second does not; mispredict_cnt=2 total.
- JUMP at 0x200, target 0x400 -> ctr=11. Three not-taken BNE at 0x200 -> ctr 11->10->01->00; a fourth holds at 00.
- Aliasing: entry for 0x100 present, NOOP at 0x100 with ex_pred_taken=1, pred_target=0x80 -> mispredict=1, redirect_pc=0x104, entry invalidated. Also: PC 0x140 (same index, ENTRIES=16) misses on tag.
- Resolve a mispredicting BLT and assert rst_n=0 on the following edge -> mispredict=0 and counters=0. Also cover ex_pc=0xFFFFFFFC not-taken, which gives redirect_pc=0x00000000.
